// File: rtl/mul_pkg.sv
// ---------------------------------------------------------------------------
// mul_pkg
// Shared definitions for the multiplier arbiter slice.
//   state_t          : sequencer state encoding (3 bits, five states)
//   DEFAULT_WIDTH    : default operand width
//   DEFAULT_TIMEOUT  : default number of WAIT cycles before a job is aborted
// ---------------------------------------------------------------------------
package mul_pkg;

    localparam int DEFAULT_WIDTH   = 32;
    localparam int DEFAULT_TIMEOUT = 255;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-input round-robin grant. The pointer names the preferred requester and
// only moves when the update strobe is high, at which point it hands
// preference to the requester that was not just served.
//   clk, reset   : clock, synchronous active-high reset (pointer -> 0)
//   req0, req1   : request lines
//   update       : pointer-update strobe
//   served       : index of the requester whose job just completed
//   grant_valid  : at least one request is present
//   grant_idx    : index of the requester that would be granted now
// ---------------------------------------------------------------------------
module rr_arb2 (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic update,
    input  logic served,
    output logic grant_valid,
    output logic grant_idx
);

    logic pointer;

    always_ff @(posedge clk) begin
        if (reset) begin
            pointer <= 1'b0;
        end else if (update) begin
            pointer <= ~served;
        end
    end

    // A lone requester wins regardless of the pointer; the pointer only
    // breaks ties.
    always_comb begin
        grant_valid = req0 | req1;
        grant_idx   = (req0 & req1) ? pointer : req1;
    end

endmodule

// File: rtl/mul_arbiter.sv
// ---------------------------------------------------------------------------
// mul_arbiter
// Round-robin arbiter and sequencer in front of a single shared iterative
// multiplier. Grants one of two requesters, latches its operands, runs the
// multiplier clear/start/done handshake with a timeout, and returns the
// product with a one-cycle acknowledge.
//   clk, reset            : clock, synchronous active-high reset
//   req0/req1             : requests, held with operands until ack
//   a0,b0 / a1,b1         : operands per requester
//   ack0/ack1             : one-cycle completion pulse per requester
//   result, err           : product (0 on timeout) and timeout flag
//   busy                  : sequencer is not idle
//   mul_opclear           : one-cycle clear pulse to the multiplier
//   mul_opstart           : start level, held until done or timeout
//   mul_a, mul_b          : latched operands driven to the multiplier
//   mul_opdone            : multiplier completion level
//   mul_result            : multiplier product, valid with mul_opdone
// ---------------------------------------------------------------------------
module mul_arbiter
    import mul_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req0,
    input  logic               req1,
    input  logic [WIDTH-1:0]   a0,
    input  logic [WIDTH-1:0]   b0,
    input  logic [WIDTH-1:0]   a1,
    input  logic [WIDTH-1:0]   b1,
    output logic               ack0,
    output logic               ack1,
    output logic [2*WIDTH-1:0] result,
    output logic               err,
    output logic               busy,
    output logic               mul_opclear,
    output logic               mul_opstart,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    input  logic               mul_opdone,
    input  logic [2*WIDTH-1:0] mul_result
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t        state;
    logic          grant;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          arb_valid;
    logic          arb_idx;
    logic          ptr_update;

    assign ptr_update = (state == RESP);
    assign cnt_next   = cnt + CW'(1);

    rr_arb2 u_rr_arb2 (
        .clk         (clk),
        .reset       (reset),
        .req0        (req0),
        .req1        (req1),
        .update      (ptr_update),
        .served      (grant),
        .grant_valid (arb_valid),
        .grant_idx   (arb_idx)
    );

    // Sequencer with registered outputs: each output is set on the edge that
    // enters the state in which it must be visible, so mul_opclear is high
    // throughout CLEAR, mul_opstart throughout START/WAIT and the ack in RESP.
    // The WAIT check uses cnt_next so that the job is aborted after exactly
    // TIMEOUT WAIT cycles; a done arriving in that last cycle still wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= 1'b0;
            cnt         <= '0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            result      <= '0;
            err         <= 1'b0;
            busy        <= 1'b0;
            mul_opclear <= 1'b0;
            mul_opstart <= 1'b0;
            mul_a       <= '0;
            mul_b       <= '0;
        end else begin
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            mul_opclear <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        grant       <= arb_idx;
                        mul_a       <= arb_idx ? a1 : a0;
                        mul_b       <= arb_idx ? b1 : b0;
                        mul_opclear <= 1'b1;
                        busy        <= 1'b1;
                        state       <= CLEAR;
                    end
                end
                CLEAR: begin
                    mul_opstart <= 1'b1;
                    state       <= START;
                end
                START: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt_next;
                    if (mul_opdone) begin
                        result      <= mul_result;
                        err         <= 1'b0;
                        mul_opstart <= 1'b0;
                        ack0        <= ~grant;
                        ack1        <= grant;
                        state       <= RESP;
                    end else if (cnt_next == CW'(TIMEOUT)) begin
                        result      <= '0;
                        err         <= 1'b1;
                        mul_opstart <= 1'b0;
                        ack0        <= ~grant;
                        ack1        <= grant;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy        <= 1'b0;
                    mul_opstart <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule
